// File: rtl/tl_mem_responder.sv
// TileLink-UL memory responder: one A request in flight, one D beat out after a
// fixed access latency, backed by a word-addressed 64-bit RAM.
module tl_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_size,
  input  logic [7:0]  a_mask,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [63:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic        d_denied,
  output logic [63:0] d_data
);
  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [15:0] CNT_INIT = 16'(LATENCY - 1);

  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_GET              = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

  // Handshake: a transfer happens on a channel in exactly the cycle where its
  // valid and ready are both high at the rising edge; D fields stay frozen
  // while d_valid is high and d_ready is low.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d, size_q, size_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  src_q, src_d;
  logic [63:0] addr_q, addr_d, data_q, data_d;
  logic [2:0]  dop_q, dop_d, dsize_q, dsize_d;
  logic [3:0]  dsrc_q, dsrc_d;
  logic        dden_q, dden_d;
  logic [63:0] ddata_q, ddata_d;

  logic [63:0] mem_q [DEPTH];

  logic [2:0]    acc_op, acc_size;
  logic [7:0]    acc_mask, lane_base, full_lanes;
  logic [63:0]   acc_addr, acc_data, acc_diff, rdata;
  logic [IW-1:0] acc_idx;
  logic          acc_den, misalign, bad_op, do_access, mem_we;

  // The access decode reads the live A inputs only when LATENCY==1 lets the
  // access happen in the accept cycle; otherwise it reads the captured request.
  always_comb begin
    acc_op   = (state_q == ST_IDLE) ? a_opcode  : op_q;
    acc_size = (state_q == ST_IDLE) ? a_size    : size_q;
    acc_mask = (state_q == ST_IDLE) ? a_mask    : mask_q;
    acc_addr = (state_q == ST_IDLE) ? a_address : addr_q;
    acc_data = (state_q == ST_IDLE) ? a_data    : data_q;
    acc_diff = acc_addr - BASE;
    acc_idx  = acc_diff[IW+2:3];
    lane_base = 8'h00;
    misalign  = 1'b0;
    case (acc_size)
      3'd0: lane_base = 8'h01;
      3'd1: begin lane_base = 8'h03; misalign = acc_addr[0];       end
      3'd2: begin lane_base = 8'h0F; misalign = |acc_addr[1:0];    end
      3'd3: begin lane_base = 8'hFF; misalign = |acc_addr[2:0];    end
      default: ;
    endcase
    full_lanes = lane_base << acc_addr[2:0];
    bad_op = !(acc_op == TL_PUT_FULL_DATA || acc_op == TL_PUT_PARTIAL_DATA ||
               acc_op == TL_GET);
    acc_den = (acc_diff >= SPAN) || (acc_size > 3'd3) || misalign || bad_op ||
              (acc_op == TL_PUT_FULL_DATA && acc_mask != full_lanes) ||
              (acc_mask == 8'h00);
    rdata = mem_q[acc_idx];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    size_d    = size_q;
    mask_d    = mask_q;
    src_d     = src_q;
    addr_d    = addr_q;
    data_d    = data_q;
    dop_d     = dop_q;
    dsize_d   = dsize_q;
    dsrc_d    = dsrc_q;
    dden_d    = dden_q;
    ddata_d   = ddata_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_valid && a_ready) begin
          op_d   = a_opcode;
          size_d = a_size;
          mask_d = a_mask;
          src_d  = a_source;
          addr_d = a_address;
          data_d = a_data;
          dsrc_d = a_source;
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 16'd1) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_RESP: begin
        if (d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_access) begin
      dop_d   = (acc_op == TL_GET || acc_den) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      dsize_d = acc_size;
      dden_d  = acc_den;
      ddata_d = (acc_op == TL_GET && !acc_den) ? rdata : 64'd0;
    end
    mem_we = do_access && !acc_den && (acc_op != TL_GET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      size_q  <= '0;
      mask_q  <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dop_q   <= '0;
      dsize_q <= '0;
      dsrc_q  <= '0;
      dden_q  <= 1'b0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      size_q  <= size_d;
      mask_q  <= mask_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dop_q   <= dop_d;
      dsize_q <= dsize_d;
      dsrc_q  <= dsrc_d;
      dden_q  <= dden_d;
      ddata_q <= ddata_d;
    end
  end

  // RAM has no reset; a reset in the write cycle cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (acc_mask[i]) mem_q[acc_idx][i*8 +: 8] <= acc_data[i*8 +: 8];
      end
    end
  end

  assign a_ready  = (state_q == ST_IDLE) && !rst;
  assign d_valid  = (state_q == ST_RESP);
  assign d_opcode = dop_q;
  assign d_size   = dsize_q;
  assign d_source = dsrc_q;
  assign d_denied = dden_q;
  assign d_data   = ddata_q;
endmodule

// File: doc/tl_mem_responder.md
# tl_mem_responder

TileLink-UL responder (slave) backed by a word-addressed 64-bit RAM; it is the memory end of the A/D channel pair whose D-channel `AccessAckData` beats fill the data cache. It accepts one Get/PutFullData/PutPartialData request at a time on channel A. After a programmable access latency it returns exactly one AccessAck or AccessAckData beat on channel D. It sits on the data-side bus behind the load/store unit and serves as the on-chip data RAM and as the bench memory model.

## Interface
- `DEPTH`, 256: number of 64-bit words; power of two, minimum 2.
- `BASE`, 64'h8000_0000: byte address of word 0; aligned to `DEPTH*8`.
- `LATENCY`, 2: cycles from A-channel fire to first `d_valid`; minimum 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `a_valid`  in  1  request valid.
- `a_ready`  out  1  responder can accept a request.
- `a_opcode`  in  3  `TL_PUT_FULL_DATA`(0), `TL_PUT_PARTIAL_DATA`(1), `TL_GET`(4), from isa.vh.
- `a_size`  in  3  log2 bytes; legal 0..3.
- `a_mask`  in  8  byte lanes within the aligned word.
- `a_source`  in  4  requester ID, echoed on D.
- `a_address`  in  64  byte address.
- `a_data`  in  64  write data, lane-aligned.
- `d_valid`  out  1  response valid.
- `d_ready`  in  1  requester accepts the response.
- `d_opcode`  out  3  `TL_ACCESS_ACK`(0) or `TL_ACCESS_ACK_DATA`(1).
- `d_size`  out  3  echo of `a_size`.
- `d_source`  out  4  echo of `a_source`.
- `d_denied`  out  1  request rejected; no RAM side effect.
- `d_data`  out  64  whole aligned word for Get; 0 otherwise.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `a_ready`=1.
  - On `a_valid & a_ready`, capture opcode, size, source, mask, address and data.
  - Load the wait counter with `LATENCY-1`, then go to WAIT.
  - If `LATENCY==1`, go straight to RESP.
- WAIT:
  - `a_ready`=0. Decrement the counter each cycle.
  - At 0, perform the RAM access and go to RESP.
- RESP:
  - `d_valid`=1 with all D fields held stable until `d_valid & d_ready`; then return to IDLE.
  - `a_ready` stays 0 in RESP. Back-to-back throughput is one request per `LATENCY+1` cycles at best.
- Index = `(a_address - BASE) >> 3`, truncated to log2(`DEPTH`) bits.
- Denial (`d_denied`=1, `d_data`=0, RAM untouched) on any of:
  - Address outside [`BASE`, `BASE + DEPTH*8`).
  - `a_size` > 3.
  - Address not aligned to `1<<a_size`.
  - Unknown opcode.
  - PutFullData whose mask is not exactly the lanes covered by size/offset.
  - Any request with `a_mask`==0.
- Get: `d_opcode`=AccessAckData, `d_data`=RAM[index] (the full word, unshifted).
  - The requester does lane extraction and sign extension.
  - `d_opcode`=AccessAckData is also used when denied.
- Put: for each lane i with `a_mask[i]`=1, write byte i of `a_data` into RAM[index]; other lanes are unchanged. `d_opcode`=AccessAck.
- RAM contents are not reset; contents are undefined until written.

## Timing
- During and after reset: `a_ready`=0 while `rst`=1; `a_ready`=1 the first cycle after `rst` falls.
  - `d_valid`=0, `d_opcode`=0, `d_size`=0, `d_source`=0, `d_denied`=0, `d_data`=0; FSM=IDLE.
- Request fires in cycle N; `d_valid` rises in cycle N+`LATENCY`.
- A Put's RAM write is visible to a Get that fires at or after the Put's D fire.
- `d_ready` held low: RESP persists indefinitely with stable outputs, and no new request is accepted.
- `d_ready` already high when `d_valid` rises: fire in that cycle, IDLE next cycle, `a_ready`=1.
- `rst` asserted in WAIT or RESP: any in-flight response is discarded.
  - A Put whose write stage was not yet reached is not performed.
  - Outputs take reset values the next cycle.
- Index arithmetic: the subtraction is 64-bit. The range check uses the untruncated difference, so addresses below `BASE` cannot alias.

## Test plan
- Reset, default params: `rst`=1 for 3 cycles -> `a_ready`=0, `d_valid`=0 throughout; `a_ready`=1 the cycle after release.
- Write then read:
  - PutFull size 3, addr 0x8000_0010, data 0x1122334455667788, mask 0xFF -> AccessAck at N+2, `d_denied`=0.
  - Then Get size 3, same addr -> AccessAckData, `d_data`=0x1122334455667788.
- Partial write: PutPartial addr 0x8000_0010, mask 0x0C, data 0x0000_0000_AABB_0000 -> a following Get returns 0x11223344AABB7788.
- Denials:
  - Get at 0x8000_0800 (past end) -> `d_denied`=1, `d_data`=0.
  - PutFull size 2 at 0x8000_0012 (misaligned) -> `d_denied`=1, memory unchanged.
- Backpressure: `d_ready`=0 for 5 cycles during a Get response -> `d_valid` and `d_data` stable, `a_ready`=0; a fire on cycle 6 -> IDLE the next cycle.
- Reset mid-flight with `LATENCY`=4: PutFull to word 3, `rst` pulsed in WAIT -> no D beat; a later Get of word 3 returns the previously written value.
